fifo_mem: RTL and testbench

Synchronous single-clock FIFO memory: the responder on the `fifo_if` bus that the testbench driver writes into and reads from, and that the monitor observes. It accepts `wr`/`rd` requests with `data_in` each clock and returns `data_out`, `full` and `empty`. It adds occupancy, almost-full/empty and sticky error outputs for the scoreboard.

---
 rtl/fifo_pkg.sv | 21 ++
 rtl/fifo_if.sv | 31 +++
 rtl/fifo_ram.sv | 29 ++
 rtl/fifo_mem.sv | 86 ++++++++
 tb/tb_fifo_mem.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants, pointer-width helper and status struct for the FIFO
package fifo_pkg;

  localparam int FIFO_DATA_W = 8;
  localparam int FIFO_DEPTH  = 16;

  // Pointer width for a power-of-two depth
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage

// File: rtl/fifo_if.sv
// rtl/fifo_if.sv - request/response bus between the FIFO driver/monitor and the FIFO memory
interface fifo_if import fifo_pkg::*; #(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int DEPTH  = FIFO_DEPTH
);

  localparam int CNT_W = ptr_w(DEPTH) + 1;

  logic [DATA_W-1:0] data_in;
  logic              wr;
  logic              rd;
  logic [DATA_W-1:0] data_out;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              underflow;

  modport master (
    output data_in, wr, rd,
    input  data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  data_in, wr, rd,
    output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

endinterface

// File: rtl/fifo_ram.sv
// rtl/fifo_ram.sv - DEPTH x DATA_W storage with one write port and a registered read port
module fifo_ram import fifo_pkg::*; #(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int DEPTH  = FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [ptr_w(DEPTH)-1:0]  waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     re,
  input  logic [ptr_w(DEPTH)-1:0]  raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage is never reset; stale words are unreachable once the pointers reset
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read register holds its value unless a read is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - single-clock FIFO: pointers, occupancy, status flags and sticky errors
module fifo_mem import fifo_pkg::*; #(
  parameter int DATA_W   = FIFO_DATA_W,
  parameter int DEPTH    = FIFO_DEPTH,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2
) (
  input logic   clk,
  input logic   rst,
  fifo_if.slave bus
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_next;
  logic             wr_ok;
  logic             rd_ok;
  logic [DATA_W-1:0] rdata;
  fifo_status_t     st_q;

  // Acceptance uses the registered flags; a simultaneous write cannot feed an empty read
  always_comb begin
    wr_ok      = bus.wr && !st_q.full;
    rd_ok      = bus.rd && !st_q.empty;
    count_next = count_q;
    if (wr_ok && !rd_ok)      count_next = count_q + CNT_W'(1);
    else if (rd_ok && !wr_ok) count_next = count_q - CNT_W'(1);
  end

  // Pointers wrap naturally at DEPTH; occupancy tracks accepted operations
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      count_q <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + PTR_W'(1);
      if (rd_ok) rptr <= rptr + PTR_W'(1);
      count_q <= count_next;
    end
  end

  // Flags come from the next count so they line up with the registered count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q.full         <= 1'b0;
      st_q.empty        <= 1'b1;
      st_q.almost_full  <= 1'b0;
      st_q.almost_empty <= 1'b1;
      st_q.overflow     <= 1'b0;
      st_q.underflow    <= 1'b0;
    end else begin
      st_q.full         <= (count_next == CNT_W'(DEPTH));
      st_q.empty        <= (count_next == '0);
      st_q.almost_full  <= (count_next >= CNT_W'(AF_LEVEL));
      st_q.almost_empty <= (count_next <= CNT_W'(AE_LEVEL));
      if (bus.wr && st_q.full)  st_q.overflow  <= 1'b1;
      if (bus.rd && st_q.empty) st_q.underflow <= 1'b1;
    end
  end

  fifo_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_ok),
    .waddr (wptr),
    .wdata (bus.data_in),
    .re    (rd_ok),
    .raddr (rptr),
    .rdata (rdata)
  );

  assign bus.data_out     = rdata;
  assign bus.count        = count_q;
  assign bus.full         = st_q.full;
  assign bus.empty        = st_q.empty;
  assign bus.almost_full  = st_q.almost_full;
  assign bus.almost_empty = st_q.almost_empty;
  assign bus.overflow     = st_q.overflow;
  assign bus.underflow    = st_q.underflow;

endmodule

// File: tb/tb_fifo_mem.sv
// tb/tb_fifo_mem.sv - directed bench for fifo_mem with a queue-based reference model
module tb_fifo_mem;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fifo_if #(.DATA_W(DW), .DEPTH(DEPTH)) bus ();

  fifo_mem #(.DATA_W(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of words plus held read data and sticky errors
  int unsigned q[$];
  int m_dout = 0;
  bit m_ovf  = 1'b0;
  bit m_unf  = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_dout = 0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
    end else begin
      int sz;
      sz = q.size();
      if (bus.rd && sz > 0) m_dout = int'(q.pop_front());
      if (bus.rd && sz == 0) m_unf = 1'b1;
      if (bus.wr && sz < DEPTH) q.push_back(int'(bus.data_in));
      if (bus.wr && sz == DEPTH) m_ovf = 1'b1;
    end
  end

  // Every cycle out of reset, all outputs must agree with the model
  always @(negedge clk) begin
    if (!rst) begin
      int sz;
      sz = q.size();
      chk("cyc_count",    int'(bus.count),        sz);
      chk("cyc_full",     int'(bus.full),         int'(sz == DEPTH));
      chk("cyc_empty",    int'(bus.empty),        int'(sz == 0));
      chk("cyc_afull",    int'(bus.almost_full),  int'(sz >= AF));
      chk("cyc_aempty",   int'(bus.almost_empty), int'(sz <= AE));
      chk("cyc_overflow", int'(bus.overflow),     int'(m_ovf));
      chk("cyc_underflow",int'(bus.underflow),    int'(m_unf));
      chk("cyc_data_out", int'(bus.data_out),     m_dout);
    end
  end

  task automatic step(input bit w, input bit r, input int d);
    bus.wr      = w;
    bus.rd      = r;
    bus.data_in = DW'(d);
    @(posedge clk);
    #1;
    bus.wr = 1'b0;
    bus.rd = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_count"},  int'(bus.count),        0);
    chk({tag, "_empty"},  int'(bus.empty),        1);
    chk({tag, "_aempty"}, int'(bus.almost_empty), 1);
    chk({tag, "_full"},   int'(bus.full),         0);
    chk({tag, "_afull"},  int'(bus.almost_full),  0);
    chk({tag, "_dout"},   int'(bus.data_out),     0);
    chk({tag, "_ovf"},    int'(bus.overflow),     0);
    chk({tag, "_unf"},    int'(bus.underflow),    0);
  endtask

  initial begin
    bus.wr      = 1'b0;
    bus.rd      = 1'b0;
    bus.data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("rst0");
    rst = 1'b0;

    // Fill to full; almost_full first appears at 14 entries
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, i);
      if (i == 0)  chk("first_write_count", int'(bus.count), 1);
      if (i == 0)  chk("first_write_empty", int'(bus.empty), 0);
      if (i == 12) chk("afull_at_13", int'(bus.almost_full), 0);
      if (i == 13) chk("afull_at_14", int'(bus.almost_full), 1);
    end
    chk("fill_full",  int'(bus.full),  1);
    chk("fill_count", int'(bus.count), 16);

    // Write while full is dropped and flagged
    step(1'b1, 1'b0, 8'hAA);
    chk("ovf_count", int'(bus.count),    16);
    chk("ovf_flag",  int'(bus.overflow), 1);

    // Drain in order
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 0);
      chk("drain_data", int'(bus.data_out), i);
    end
    chk("drain_empty", int'(bus.empty), 1);
    step(1'b0, 1'b1, 0);
    chk("unf_flag", int'(bus.underflow), 1);
    chk("unf_hold", int'(bus.data_out),  8'h0F);

    // Wrap-around
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'h10 + i);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 0);
      chk("wrap_a_data", int'(bus.data_out), 8'h10 + i);
    end
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 8'h20 + i);
    chk("wrap_count12", int'(bus.count), 12);
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1, 0);
      chk("wrap_b_data", int'(bus.data_out), 8'h20 + i);
    end
    chk("wrap_count0", int'(bus.count), 0);

    // Simultaneous traffic at occupancy 5
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'h30 + i);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 8'h40 + i);
      chk("sim_count", int'(bus.count), 5);
      chk("sim_data", int'(bus.data_out), (i < 5) ? (8'h30 + i) : (8'h40 + i - 5));
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 0);
      chk("sim_tail", int'(bus.data_out), 8'h4F + i);
    end

    // Simultaneous at empty (fresh sticky flags), then at full
    do_reset();
    chk_reset_vals("rst1");
    step(1'b1, 1'b1, 8'h60);
    chk("both_empty_count", int'(bus.count),     1);
    chk("both_empty_unf",   int'(bus.underflow), 1);
    chk("both_empty_dout",  int'(bus.data_out),  0);
    for (int i = 1; i < 16; i++) step(1'b1, 1'b0, 8'h60 + i);
    chk("both_full_pre", int'(bus.count), 16);
    step(1'b1, 1'b1, 8'h99);
    chk("both_full_count", int'(bus.count),    15);
    chk("both_full_ovf",   int'(bus.overflow), 1);
    chk("both_full_dout",  int'(bus.data_out), 8'h60);
    for (int i = 1; i < 16; i++) begin
      step(1'b0, 1'b1, 0);
      chk("both_full_drain", int'(bus.data_out), 8'h60 + i);
    end

    // Asynchronous reset mid-stream at occupancy 7
    do_reset();
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 8'h70 + i);
    step(1'b0, 1'b1, 0);
    step(1'b1, 1'b0, 8'h7F);
    chk("mid_count7", int'(bus.count), 7);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_vals("rst_async");
    rst = 1'b0;
    step(1'b1, 1'b0, 8'h77);
    chk("post_rst_count", int'(bus.count), 1);
    step(1'b0, 1'b1, 0);
    chk("post_rst_data",  int'(bus.data_out), 8'h77);
    chk("post_rst_empty", int'(bus.empty),    1);

    repeat (2) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
